pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Parametrised pipeline hazard controller for the NSTAGE-deep in-order CPU pipeline. It merges per-stage stall requests into a stage-prefix stall vector, with stage 0 = PC and higher index = older stage. It also converts exception/redirect requests into a registered one-cycle flush with a target PC. A consecutive-stall watchdog detects livelock.

Parameters:
NSTAGE, 6, number of pipeline stages; width of stall vector (0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB)
AW, 32, PC/redirect address width
WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
stallreq  input  NSTAGE  bit i = stage i requests stall (level, held until satisfied)
flushreq  input  1  exception/redirect request (level, held until flush observed)
flush_pc  input  AW  redirect target, valid with flushreq
stall  output  NSTAGE  bit i = hold stage i this cycle
flush  output  1  one-cycle pulse: kill all in-flight instructions
new_pc  output  AW  redirect target, valid while flush=1
wdog_timeout  output  1  sticky livelock indicator

Behaviour:
- State machine, 2 states: RUN, FLUSH. Reset -> RUN.
- Reset values: stall=0, flush=0, new_pc=0, wdog_timeout=0, watchdog counter=0.
- Stall (combinational, zero latency, valid only in RUN):
  - k = highest index i with stallreq[i]=1.
  - stall[j]=1 for all j<=k; stall[j]=0 for j>k.
  - No request -> stall=0.
  - Examples: stallreq=6'b000100 -> 6'b000111; 6'b001000 -> 6'b001111; 6'b001100 -> 6'b001111 (oldest requester wins).
  - stallreq[0] alone -> 6'b000001.
- Flush:
  - RUN, flushreq=1 at edge -> next state FLUSH; new_pc <= flush_pc in that same edge.
  - FLUSH lasts exactly 1 cycle: flush=1, stall forced to all-zero regardless of stallreq, new_pc stable.
  - FLUSH -> RUN unconditionally. flush=0 in RUN; new_pc holds its last value.
  - flushreq sampled only in RUN; a request still high in the FLUSH cycle is not re-taken. The requester deasserts on seeing flush. If still high in the following RUN cycle, it is treated as a new flush.
  - flushreq and stallreq in the same RUN cycle: stall output per stallreq that cycle; flush taken next cycle (flush overrides stall).
- Watchdog:
  - cnt increments on every RUN cycle with stall!=0.
  - cnt clears on any cycle with stall==0 (including FLUSH).
  - Counter width $clog2(WDOG_LIMIT+1); saturates at WDOG_LIMIT.
  - When cnt reaches WDOG_LIMIT, wdog_timeout <= 1 and stays 1 until rst.
- Reset mid-FLUSH: next cycle RUN, flush=0, new_pc=0.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: adds outputs perf_stall_cycles[31:0] and perf_flush_cnt[31:0], both reset 0 and wrapping at 2^32.
  - perf_stall_cycles increments on every cycle with stall!=0.
  - perf_flush_cnt increments on every cycle with flush=1.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package/defines: STALLBUS width default, stage index constants (STG_PC..STG_WB), RUN/FLUSH state encoding, Stop/NoStop level constants.
- One natural sub-module: stall_prefix (combinational priority-to-prefix mask, parametrised by NSTAGE), instantiated once.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all inputs 0 -> stall=0, flush=0, new_pc=0, wdog_timeout=0.
- Prefix stall: stallreq=6'b000100 -> stall=6'b000111 same cycle; 6'b001100 -> 6'b001111; 6'b100001 -> 6'b111111.
- Flush: flushreq=1, flush_pc=32'h0000_8000 held 2 cycles -> one cycle later flush=1 for exactly 1 cycle with new_pc=32'h0000_8000; a second flush occurs only if flushreq remains high in the subsequent RUN cycle.
- Flush overrides stall: stallreq=6'b001000 held while flushreq pulses -> FLUSH cycle shows stall=0, flush=1; following cycle stall=6'b001111.
- Watchdog (WDOG_LIMIT=4): stallreq[3]=1 for 3 cycles then 0 -> no timeout. Then held 4 cycles -> wdog_timeout=1 and stays 1 after stallreq clears, until rst.
- PIPE_CTRL_PERF_EN: 5 stalled cycles + 2 flushes -> perf_stall_cycles=5, perf_flush_cnt=2.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
// Optional perf counters in pipe_ctrl are enabled by defining PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    localparam int unsigned STALLBUS_W = 6;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_stall_prefix.sv
// Priority-to-prefix mask: every stage at or younger than the oldest requester is held.
module pipe_ctrl_stall_prefix
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE = STALLBUS_W
) (
    input  logic [NSTAGE-1:0] i_req,
    output logic [NSTAGE-1:0] o_mask
);

    logic w_acc;

    // Walk from the oldest stage down, OR-accumulating requests.
    always_comb begin
        w_acc  = NoStop;
        o_mask = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            w_acc     = w_acc | i_req[i];
            o_mask[i] = w_acc;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: prefix stall merge, registered one-cycle flush, livelock watchdog.
// Define PIPE_CTRL_PERF_EN to add stall-cycle and flush performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE     = STALLBUS_W,
    parameter int unsigned AW         = 32,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NSTAGE-1:0] i_stallreq,
    input  logic              i_flushreq,
    input  logic [AW-1:0]     i_flush_pc,
    output logic [NSTAGE-1:0] o_stall,
    output logic              o_flush,
    output logic [AW-1:0]     o_new_pc,
    output logic              o_wdog_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       o_perf_stall_cycles,
    output logic [31:0]       o_perf_flush_cnt
`endif
);

    localparam int unsigned CW = $clog2(WDOG_LIMIT + 1);

    state_e            r_state;
    logic              r_flush;
    logic [AW-1:0]     r_new_pc;
    logic [CW-1:0]     r_wdog_cnt;
    logic              r_wdog_timeout;
    logic [NSTAGE-1:0] w_prefix;
    logic [NSTAGE-1:0] w_stall;
    logic              w_stall_any;

    pipe_ctrl_stall_prefix #(
        .NSTAGE (NSTAGE)
    ) u_stall_prefix (
        .i_req  (i_stallreq),
        .o_mask (w_prefix)
    );

    // The flush cycle kills everything in flight, so nothing is held then.
    always_comb begin
        w_stall     = (r_state == StRun) ? w_prefix : {NSTAGE{NoStop}};
        w_stall_any = |w_stall;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StRun;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    if (i_flushreq) begin
                        r_state  <= StFlush;
                        r_flush  <= 1'b1;
                        r_new_pc <= i_flush_pc;
                    end
                end
                StFlush: begin
                    r_state <= StRun;
                    r_flush <= 1'b0;
                end
                default: begin
                    r_state <= StRun;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

    // Timeout is raised on the same edge the counter reaches the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog_cnt     <= '0;
            r_wdog_timeout <= 1'b0;
        end else if (w_stall_any) begin
            if (r_wdog_cnt != CW'(WDOG_LIMIT)) begin
                r_wdog_cnt <= r_wdog_cnt + CW'(1);
            end
            if (r_wdog_cnt >= CW'(WDOG_LIMIT - 1)) begin
                r_wdog_timeout <= 1'b1;
            end
        end else begin
            r_wdog_cnt <= '0;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_flush_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_stall_cycles <= '0;
            r_perf_flush_cnt    <= '0;
        end else begin
            if (w_stall_any) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            if (r_flush) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_stall_cycles = r_perf_stall_cycles;
    assign o_perf_flush_cnt    = r_perf_flush_cnt;
`endif

    assign o_stall        = w_stall;
    assign o_flush        = r_flush;
    assign o_new_pc       = r_new_pc;
    assign o_wdog_timeout = r_wdog_timeout;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: per-cycle vector table through a scoreboard queue,
// plus hand-written reset, watchdog and reset-during-flush sequences.
module tb_pipe_ctrl;

    localparam int unsigned NSTAGE = 6;
    localparam int unsigned AW     = 32;
    localparam int unsigned NVEC   = 22;

    typedef struct packed {
        logic [NSTAGE-1:0] req;
        logic              fr;
        logic [AW-1:0]     pc;
        logic [NSTAGE-1:0] exp_stall;
        logic              exp_flush;
        logic [AW-1:0]     exp_npc;
        logic              exp_to;
    } vec_t;

    logic              clk;
    logic              rst;
    logic [NSTAGE-1:0] stallreq;
    logic              flushreq;
    logic [AW-1:0]     flush_pc;
    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [AW-1:0]     new_pc;
    logic              wdog_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[NVEC];
    vec_t sb[$];

    pipe_ctrl #(
        .NSTAGE     (NSTAGE),
        .AW         (AW),
        .WDOG_LIMIT (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stallreq     (stallreq),
        .i_flushreq     (flushreq),
        .i_flush_pc     (flush_pc),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_new_pc       (new_pc),
        .o_wdog_timeout (wdog_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .o_perf_stall_cycles (perf_stall_cycles),
        .o_perf_flush_cnt    (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic [NSTAGE-1:0] req, input logic fr, input logic [AW-1:0] pc);
        @(posedge clk);
        #1;
        stallreq = req;
        flushreq = fr;
        flush_pc = pc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        stallreq = '0;
        flushreq = 1'b0;
        flush_pc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " stall"}, 64'(stall), 64'(0));
        check({tag, " flush"}, 64'(flush), 64'(0));
        check({tag, " new_pc"}, 64'(new_pc), 64'(0));
        check({tag, " wdog"}, 64'(wdog_timeout), 64'(0));
    endtask

    initial begin
        vec_t e;

        //           req        fr  pc            stall      fl  npc           to
        vecs[0]  = '{6'b000000, 0, 32'h0,        6'b000000, 0, 32'h0,        0};
        vecs[1]  = '{6'b000100, 0, 32'h0,        6'b000111, 0, 32'h0,        0};
        vecs[2]  = '{6'b001100, 0, 32'h0,        6'b001111, 0, 32'h0,        0};
        vecs[3]  = '{6'b100001, 0, 32'h0,        6'b111111, 0, 32'h0,        0};
        vecs[4]  = '{6'b000000, 0, 32'h0,        6'b000000, 0, 32'h0,        0};
        vecs[5]  = '{6'b000001, 0, 32'h0,        6'b000001, 0, 32'h0,        0};
        vecs[6]  = '{6'b001000, 0, 32'h0,        6'b001111, 0, 32'h0,        0};
        vecs[7]  = '{6'b000000, 1, 32'h0000_8000, 6'b000000, 0, 32'h0,        0};
        vecs[8]  = '{6'b000000, 1, 32'h0000_8000, 6'b000000, 1, 32'h0000_8000, 0};
        vecs[9]  = '{6'b000000, 0, 32'h0,        6'b000000, 0, 32'h0000_8000, 0};
        vecs[10] = '{6'b001000, 1, 32'h0000_1234, 6'b001111, 0, 32'h0000_8000, 0};
        vecs[11] = '{6'b001000, 0, 32'h0,        6'b000000, 1, 32'h0000_1234, 0};
        vecs[12] = '{6'b001000, 0, 32'h0,        6'b001111, 0, 32'h0000_1234, 0};
        vecs[13] = '{6'b000000, 1, 32'h0000_aaaa, 6'b000000, 0, 32'h0000_1234, 0};
        vecs[14] = '{6'b000000, 1, 32'h0000_aaaa, 6'b000000, 1, 32'h0000_aaaa, 0};
        vecs[15] = '{6'b000000, 1, 32'h0000_bbbb, 6'b000000, 0, 32'h0000_aaaa, 0};
        vecs[16] = '{6'b000000, 0, 32'h0,        6'b000000, 1, 32'h0000_bbbb, 0};
        vecs[17] = '{6'b000000, 0, 32'h0,        6'b000000, 0, 32'h0000_bbbb, 0};
        vecs[18] = '{6'b100000, 0, 32'h0,        6'b111111, 0, 32'h0000_bbbb, 0};
        vecs[19] = '{6'b010000, 0, 32'h0,        6'b011111, 0, 32'h0000_bbbb, 0};
        vecs[20] = '{6'b000010, 0, 32'h0,        6'b000011, 0, 32'h0000_bbbb, 0};
        vecs[21] = '{6'b000000, 0, 32'h0,        6'b000000, 0, 32'h0000_bbbb, 0};

        rst      = 1'b1;
        stallreq = '0;
        flushreq = 1'b0;
        flush_pc = '0;
        do_reset();
        check_idle("reset");

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            stallreq = vecs[i].req;
            flushreq = vecs[i].fr;
            flush_pc = vecs[i].pc;
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("vec%0d stall", i), 64'(stall), 64'(e.exp_stall));
            check($sformatf("vec%0d flush", i), 64'(flush), 64'(e.exp_flush));
            check($sformatf("vec%0d new_pc", i), 64'(new_pc), 64'(e.exp_npc));
            check($sformatf("vec%0d wdog", i), 64'(wdog_timeout), 64'(e.exp_to));
        end
`ifdef PIPE_CTRL_PERF_EN
        check("table perf_stall", 64'(perf_stall_cycles), 64'(10));
        check("table perf_flush", 64'(perf_flush_cnt), 64'(4));
`endif

        // Watchdog: three stalled cycles then a gap must not trip.
        do_reset();
        check_idle("wdog reset");
        for (int i = 0; i < 3; i++) cyc(6'b001000, 1'b0, '0);
        cyc(6'b000000, 1'b0, '0);
        check("wdog after 3", 64'(wdog_timeout), 64'(0));
        for (int i = 0; i < 4; i++) begin
            cyc(6'b001000, 1'b0, '0);
            check($sformatf("wdog run %0d", i), 64'(wdog_timeout), 64'(0));
        end
        cyc(6'b000000, 1'b0, '0);
        check("wdog after 4", 64'(wdog_timeout), 64'(1));
        for (int i = 0; i < 3; i++) begin
            cyc(6'b000000, 1'b0, '0);
            check($sformatf("wdog sticky %0d", i), 64'(wdog_timeout), 64'(1));
        end
        do_reset();
        check("wdog cleared", 64'(wdog_timeout), 64'(0));

        // Reset arriving during the flush cycle.
        cyc(6'b000000, 1'b1, 32'h0000_5555);
        check("rstflush pre", 64'(flush), 64'(0));
        @(posedge clk);
        #1;
        flushreq = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("rstflush flush", 64'(flush), 64'(1));
        check("rstflush pc", 64'(new_pc), 64'(32'h0000_5555));
        @(posedge clk);
        #1;
        rst      = 1'b0;
        stallreq = 6'b000100;
        @(negedge clk);
        check("rstflush after flush", 64'(flush), 64'(0));
        check("rstflush after pc", 64'(new_pc), 64'(0));
        check("rstflush after stall", 64'(stall), 64'(6'b000111));

`ifdef PIPE_CTRL_PERF_EN
        do_reset();
        check("perf reset stall", 64'(perf_stall_cycles), 64'(0));
        check("perf reset flush", 64'(perf_flush_cnt), 64'(0));
        for (int i = 0; i < 5; i++) cyc(6'b000010, 1'b0, '0);
        cyc(6'b000000, 1'b1, 32'h0000_0100);
        cyc(6'b000000, 1'b0, '0);
        cyc(6'b000000, 1'b1, 32'h0000_0200);
        cyc(6'b000000, 1'b0, '0);
        cyc(6'b000000, 1'b0, '0);
        check("perf stall", 64'(perf_stall_cycles), 64'(5));
        check("perf flush", 64'(perf_flush_cnt), 64'(2));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
